stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per channel (>=1).
REQ-002 SHALL have parameter CHANNELS, default 8: number of output channels (2..64).
REQ-003 SHALL have localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-004 Clock/reset: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  async active-high reset.
REQ-007 SHALL have port in_data  input  WIDTH  upstream data.
REQ-008 SHALL have port in_valid  input  1  upstream data valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle (combinational).
REQ-010 SHALL have port sel  input  SEL_W  channel select used in fixed mode.
REQ-011 SHALL have port mode  input  1  0 = fixed (sel), 1 = round-robin.
REQ-012 SHALL have port out_data  output  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port out_valid  output  CHANNELS  per-channel valid.
REQ-014 SHALL have port out_ready  input  CHANNELS  per-channel downstream ready.
REQ-015 SHALL have port cur_ch  output  SEL_W  current target channel.

Function
REQ-016 Target SHALL be sel when mode=0, else the round-robin pointer ptr; cur_ch SHALL equal the target.
REQ-017 While mode=0, ptr SHALL load sel every cycle, so round-robin resumes from the last fixed channel.
REQ-018 Each channel SHALL own a one-entry register (data + valid).
REQ-019 in_ready SHALL be ~out_valid[target] | out_ready[target], forced 0 when the target >= CHANNELS.
REQ-020 Transfer SHALL occur on in_valid & in_ready; data SHALL appear on the target channel with out_valid high on the next cycle (latency 1).
REQ-021 In mode=1, ptr SHALL advance by 1 only on a transfer, wrapping CHANNELS-1 -> 0; with no transfer, ptr SHALL hold.
REQ-022 A channel SHALL clear out_valid when out_ready is high and it is not reloaded that cycle.
REQ-023 Simultaneous drain and load on one channel SHALL keep out_valid=1 with the new data (no bubble).
REQ-024 Non-target channels SHALL drain independently; a transfer SHALL never alter another channel.
REQ-025 out_data SHALL hold its last value after drain; only out_valid marks validity.
REQ-026 A stalled target SHALL block input (in_ready=0); the block SHALL never drop or duplicate data.
REQ-027 A mode or sel change SHALL take effect the same cycle, combinationally, with no pending state lost.

Reset
REQ-028 On rst=1, all out_valid SHALL be 0, all out_data 0, and ptr 0, independent of clk.
REQ-029 Reset mid-transfer SHALL discard all buffered data; no output SHALL assert until a new transfer after rst falls.

Configuration
REQ-030 With macro STREAM_DEMUX_CNT_EN defined, the block SHALL keep a 16-bit saturating accepted-transfer counter per channel, reset to 0.
REQ-031 With STREAM_DEMUX_CNT_EN defined, the block SHALL expose port cnt_out  output  16  giving the counter of cur_ch.
REQ-032 A counter at 16'hFFFF SHALL hold at 16'hFFFF.
REQ-033 Without STREAM_DEMUX_CNT_EN, neither the counters nor cnt_out SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-034 Fixed mode: mode=0, sel=3, in_data=8'hA5, 1-cycle in_valid, all out_ready=0 -> next cycle out_valid=8'b0000_1000, channel 3 data=8'hA5, in_ready=0 while sel=3.
REQ-035 Round-robin: mode=1 from reset, 10 back-to-back transfers 0x00..0x09 with out_ready all 1 -> channels 0..7 then 0,1 receive them in order; cur_ch ends at 2.
REQ-036 Backpressure: mode=1, out_ready[1]=0 with channel 1 full -> in_ready=0 at ptr=1; ptr holds; after out_ready[1]=1 for one cycle the transfer proceeds with no loss.
REQ-037 Same-cycle drain+load: channel 0 full, out_ready[0]=1, new transfer to channel 0 -> out_valid[0] stays 1 with new data.
REQ-038 Async reset: assert rst between clock edges with channels full -> out_valid=0 immediately, ptr=0; with the macro, cnt_out=0.
REQ-039 CHANNELS=5, sel=6, mode=0, in_valid=1 -> in_ready=0; no out_valid change.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to one of CHANNELS one-entry output registers, fixed (sel) or round-robin.
// Optional build macro STREAM_DEMUX_CNT_EN adds per-channel 16-bit saturating transfer counters and port cnt_out.
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int CHANNELS = 8,
   localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [SEL_W-1:0]          cur_ch
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [15:0]              cnt_out
`endif
);
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] target;
   logic             xfer;
   assign target = mode ? ptr : sel;
   assign cur_ch = target;
   assign xfer = in_valid & in_ready;
   // a target index outside the channel range matches no channel, so in_ready stays 0
   always_comb begin
      in_ready = 1'b0;
      for (int k = 0; k < CHANNELS; k++)
         if (SEL_W'(k) == target) in_ready = ~out_valid[k] | out_ready[k];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         ptr <= !mode ? sel : !xfer ? ptr : (ptr == SEL_W'(CHANNELS - 1)) ? '0 : ptr + SEL_W'(1);
         for (int k = 0; k < CHANNELS; k++) begin
            if (xfer && SEL_W'(k) == target) begin
               out_valid[k]                <= 1'b1;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end
`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] cnt [CHANNELS];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++)
            if (xfer && SEL_W'(k) == target && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
      end
   end
   always_comb begin
      cnt_out = '0;
      for (int k = 0; k < CHANNELS; k++)
         if (SEL_W'(k) == cur_ch) cnt_out = cnt[k];
   end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed and random checks of stream_demux against a channel-level reference model.
module tb_stream_demux;
   localparam int W = 8;
   localparam int C = 8;
   localparam int S = 3;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [S-1:0] sel = '0;
   logic mode = 1'b0;
   logic [C*W-1:0] out_data;
   logic [C-1:0] out_valid;
   logic [C-1:0] out_ready = '0;
   logic [S-1:0] cur_ch;
`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] cnt_out, cnt_out5;
`endif
   logic [2:0] sel5 = '0;
   logic [2:0] cur5;
   logic in_valid5 = 1'b0;
   logic in_ready5;
   logic [5*W-1:0] out_data5;
   logic [4:0] out_valid5;
   int checks = 0;
   int errors = 0;
   bit m_v[C];
   logic [W-1:0] m_d[C];
   int m_ptr;
   int m_cnt[C];

   always #5 clk = ~clk;

   stream_demux #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .cur_ch(cur_ch)
`ifdef STREAM_DEMUX_CNT_EN
      , .cnt_out(cnt_out)
`endif
   );

   stream_demux #(.WIDTH(W), .CHANNELS(5)) dut5 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid5), .in_ready(in_ready5),
      .sel(sel5), .mode(1'b0), .out_data(out_data5), .out_valid(out_valid5),
      .out_ready(5'b0), .cur_ch(cur5)
`ifdef STREAM_DEMUX_CNT_EN
      , .cnt_out(cnt_out5)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      for (int k = 0; k < C; k++) begin
         m_v[k] = 0;
         m_d[k] = '0;
         m_cnt[k] = 0;
      end
   endtask

   task automatic chk_outputs();
      logic [C-1:0] ev;
      logic [C*W-1:0] ed;
      for (int k = 0; k < C; k++) begin
         ev[k] = m_v[k];
         ed[k*W +: W] = m_d[k];
      end
      chk("out_valid", out_valid, ev);
      chk("out_data", out_data, ed);
   endtask

   // one clock cycle: check combinational outputs, advance the model, check registered outputs
   task automatic tick();
      int t = mode ? m_ptr : int'(sel);
      bit r = (t < C) && (!m_v[t] || out_ready[t]);
      bit x = in_valid && r;
      #1;
      chk("in_ready", in_ready, r);
      chk("cur_ch", cur_ch, t);
`ifdef STREAM_DEMUX_CNT_EN
      chk("cnt_out", cnt_out, m_cnt[t]);
`endif
      @(posedge clk);
      for (int k = 0; k < C; k++) if (out_ready[k]) m_v[k] = 0;
      if (x) begin
         m_v[t] = 1;
         m_d[t] = in_data;
         if (m_cnt[t] < 65535) m_cnt[t]++;
      end
      m_ptr = !mode ? int'(sel) : x ? (m_ptr + 1) % C : m_ptr;
      #1;
      chk_outputs();
   endtask

   initial begin
      model_reset();
      mode = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_cur_ch", cur_ch, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      // fixed mode single transfer to channel 3
      mode = 1'b0; sel = 3; in_data = 8'hA5; in_valid = 1'b1; out_ready = '0;
      tick();
      chk("fixed_ov", out_valid, 8'b0000_1000);
      chk("fixed_d3", out_data[3*W +: W], 8'hA5);
      in_valid = 1'b0;
      tick();
      chk("fixed_stall", in_ready, 1'b0);
      out_ready = '1;
      tick();
      // round-robin from reset, ten back-to-back transfers
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      mode = 1'b1; out_ready = '1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = W'(i);
         tick();
         chk("rr_chan", out_valid, C'(1) << (i % C));
      end
      chk("rr_end_ptr", cur_ch, 2);
      // backpressure on channel 1
      mode = 1'b0; sel = 1; in_data = 8'h55; out_ready = 8'hFD;
      tick();
      mode = 1'b1; in_data = 8'h77;
      tick();
      chk("bp_block", in_ready, 1'b0);
      tick();
      chk("bp_hold", cur_ch, 1);
      out_ready = '1;
      tick();
      chk("bp_pass", out_data[1*W +: W], 8'h77);
      chk("bp_adv", cur_ch, 2);
      // simultaneous drain and load on channel 0
      mode = 1'b0; sel = 0; out_ready = '0; in_data = 8'h11;
      tick();
      out_ready = 8'h01; in_data = 8'h22;
      tick();
      chk("dl_valid", out_valid[0], 1'b1);
      chk("dl_data", out_data[W-1:0], 8'h22);
      // async reset between edges with channels full
      mode = 1'b1; out_ready = '0;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'hC0 + W'(i);
         tick();
      end
      #3 rst = 1'b1;
      #1;
      chk("arst_ov", out_valid, '0);
      chk("arst_ptr", cur_ch, 0);
`ifdef STREAM_DEMUX_CNT_EN
      chk("arst_cnt", cnt_out, 0);
`endif
      model_reset();
      #2 rst = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         mode = 1'($urandom_range(0, 3) != 0);
         sel = S'($urandom);
         in_valid = 1'($urandom);
         in_data = W'($urandom);
         out_ready = C'($urandom) | C'($urandom);
         tick();
      end
      // out-of-range select on a five-channel instance
      sel5 = 3'd6; in_valid5 = 1'b1;
      #1;
      chk("oor_ready", in_ready5, 1'b0);
      chk("oor_cur", cur5, 6);
      @(posedge clk);
      #1;
      chk("oor_ov", out_valid5, '0);
      sel5 = 3'd4;
      #1;
      chk("ch4_ready", in_ready5, 1'b1);
      @(posedge clk);
      #1;
      chk("ch4_ov", out_valid5, 5'b10000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
